// File: rtl/trace_collector.sv
// trace_collector
//   Taps the mor1kx writeback/retire signals in front of the per-core trace
//   monitor. It keeps a shadow copy of GPR r3 and drives the monitor inputs
//   through one register stage. Selected retired instructions are captured
//   into a first-word-fall-through FIFO for a host/debug consumer. The core
//   is never stalled: events that find the FIFO full are dropped and counted,
//   and the count is attached to the next entry that does get in.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   retire_valid/pc/insn             retiring instruction
//   rf_we/rf_waddr/rf_wdata          register-file write port (r3 shadow)
//   mon_enable/pc/insn/r3            registered monitor inputs
//   out_valid/out_ready              FIFO head handshake
//   out_pc/insn/r3                   head entry payload
//   out_overflow/out_drop_count      drops that preceded the head entry
module trace_collector #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter bit          FILTER_NOP = 1'b1,
  parameter int unsigned DROP_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              retire_valid,
  input  logic [31:0]       retire_pc,
  input  logic [31:0]       retire_insn,
  input  logic              rf_we,
  input  logic [4:0]        rf_waddr,
  input  logic [31:0]       rf_wdata,
  output logic              mon_enable,
  output logic [31:0]       mon_pc,
  output logic [31:0]       mon_insn,
  output logic [31:0]       mon_r3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_insn,
  output logic [31:0]       out_r3,
  output logic              out_overflow,
  output logic [DROP_W-1:0] out_drop_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [31:0]       shadow_r3_q;
  logic [DROP_W-1:0] drop_cnt_q;
  logic [AW:0]       wr_ptr_q, rd_ptr_q;

  logic [31:0]       pc_mem_q   [FIFO_DEPTH];
  logic [31:0]       insn_mem_q [FIFO_DEPTH];
  logic [31:0]       r3_mem_q   [FIFO_DEPTH];
  logic              ovf_mem_q  [FIFO_DEPTH];
  logic [DROP_W-1:0] dcnt_mem_q [FIFO_DEPTH];

  logic        r3_wr;
  logic [31:0] snap_r3;
  logic        is_event_nop;
  logic        cap;
  logic        empty, full;
  logic        pop, push, drop;
  logic [AW-1:0] wr_idx, rd_idx;

  // Bypass a same-cycle r3 write so the snapshot reflects the state after
  // the retiring instruction.
  assign r3_wr   = rf_we && (rf_waddr == 5'd3);
  assign snap_r3 = r3_wr ? rf_wdata : shadow_r3_q;

  // l.nop K with K != 0 marks a simulation/trace event; plain l.nop 0 is filler.
  assign is_event_nop = (retire_insn[31:16] == 16'h1500) && (retire_insn[15:0] != 16'h0000);
  assign cap          = retire_valid && (!FILTER_NOP || is_event_nop);

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

  // A pop frees the slot the push needs, so a full FIFO still accepts.
  assign pop  = out_valid && out_ready;
  assign push = cap && (!full || pop);
  assign drop = cap && full && !pop;

  assign out_valid      = !empty;
  assign out_pc         = pc_mem_q[rd_idx];
  assign out_insn       = insn_mem_q[rd_idx];
  assign out_r3         = r3_mem_q[rd_idx];
  assign out_overflow   = ovf_mem_q[rd_idx];
  assign out_drop_count = dcnt_mem_q[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r3_q <= '0;
      mon_enable  <= 1'b0;
      mon_pc      <= '0;
      mon_insn    <= '0;
      mon_r3      <= '0;
    end else begin
      if (r3_wr) shadow_r3_q <= rf_wdata;
      mon_enable <= retire_valid;
      if (retire_valid) begin
        mon_pc   <= retire_pc;
        mon_insn <= retire_insn;
        mon_r3   <= snap_r3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      if (push) begin
        wr_ptr_q   <= wr_ptr_q + (AW+1)'(1);
        drop_cnt_q <= '0;
      end else if (drop && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + DROP_W'(1);
      end
    end
  end

  // Storage is cleared on reset so the head outputs read 0 while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        insn_mem_q[i] <= '0;
        r3_mem_q[i]   <= '0;
        ovf_mem_q[i]  <= 1'b0;
        dcnt_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_idx]   <= retire_pc;
      insn_mem_q[wr_idx] <= retire_insn;
      r3_mem_q[wr_idx]   <= snap_r3;
      ovf_mem_q[wr_idx]  <= (drop_cnt_q != '0);
      dcnt_mem_q[wr_idx] <= drop_cnt_q;
    end
  end

endmodule

// File: tb/tb_trace_collector.sv
module tb_trace_collector;

  localparam int unsigned Depth = 8;
  localparam int unsigned DropW = 16;
  localparam bit          Filter = 1'b1;

  logic              clk;
  logic              rst_n;
  logic              retire_valid;
  logic [31:0]       retire_pc;
  logic [31:0]       retire_insn;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;
  logic              mon_enable;
  logic [31:0]       mon_pc;
  logic [31:0]       mon_insn;
  logic [31:0]       mon_r3;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [31:0]       out_insn;
  logic [31:0]       out_r3;
  logic              out_overflow;
  logic [DropW-1:0]  out_drop_count;

  trace_collector #(
    .FIFO_DEPTH (Depth),
    .FILTER_NOP (Filter),
    .DROP_W     (DropW)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .retire_valid   (retire_valid),
    .retire_pc      (retire_pc),
    .retire_insn    (retire_insn),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .mon_enable     (mon_enable),
    .mon_pc         (mon_pc),
    .mon_insn       (mon_insn),
    .mon_r3         (mon_r3),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_insn       (out_insn),
    .out_r3         (out_r3),
    .out_overflow   (out_overflow),
    .out_drop_count (out_drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a queue of trace events plus plain scalars.
  typedef struct {
    logic [31:0]      pc;
    logic [31:0]      insn;
    logic [31:0]      r3;
    logic             ovf;
    logic [DropW-1:0] dcnt;
  } ent_t;

  ent_t             m_q[$];
  logic [DropW-1:0] m_drop;
  logic [31:0]      m_shadow;
  logic             m_men;
  logic [31:0]      m_mpc, m_minsn, m_mr3;

  int n_checks = 0;
  int n_errors = 0;
  int n_attempts = 0;
  int n_pops = 0;
  int drop_sum = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_drop   = '0;
    m_shadow = '0;
    m_men    = 1'b0;
    m_mpc    = '0;
    m_minsn  = '0;
    m_mr3    = '0;
  endtask

  task automatic model_step(input logic rv, input logic [31:0] pc, input logic [31:0] insn,
                            input logic we, input logic [4:0] wa, input logic [31:0] wd,
                            input logic rdy);
    logic [31:0] snap;
    bit          wanted;
    ent_t        e;
    snap   = (we && wa == 5'd3) ? wd : m_shadow;
    wanted = rv && (!Filter || (insn[31:16] == 16'h1500 && insn[15:0] != 16'h0));
    if (wanted) n_attempts++;
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    if (wanted) begin
      if (m_q.size() < Depth) begin
        e.pc   = pc;
        e.insn = insn;
        e.r3   = snap;
        e.ovf  = (m_drop != 0);
        e.dcnt = m_drop;
        m_q.push_back(e);
        m_drop = '0;
      end else if (m_drop != {DropW{1'b1}}) begin
        m_drop = m_drop + 1;
      end
    end
    if (we && wa == 5'd3) m_shadow = wd;
    m_men = rv;
    if (rv) begin
      m_mpc   = pc;
      m_minsn = insn;
      m_mr3   = snap;
    end
  endtask

  task automatic compare_all();
    check("mon_enable", 64'(mon_enable), 64'(m_men));
    check("mon_pc", 64'(mon_pc), 64'(m_mpc));
    check("mon_insn", 64'(mon_insn), 64'(m_minsn));
    check("mon_r3", 64'(mon_r3), 64'(m_mr3));
    check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("out_pc", 64'(out_pc), 64'(m_q[0].pc));
      check("out_insn", 64'(out_insn), 64'(m_q[0].insn));
      check("out_r3", 64'(out_r3), 64'(m_q[0].r3));
      check("out_overflow", 64'(out_overflow), 64'(m_q[0].ovf));
      check("out_drop_count", 64'(out_drop_count), 64'(m_q[0].dcnt));
    end
  endtask

  // Called at a falling edge: drive, let the rising edge happen, compare.
  task automatic cycle(input logic rv, input logic [31:0] pc, input logic [31:0] insn,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rdy);
    retire_valid = rv;
    retire_pc    = pc;
    retire_insn  = insn;
    rf_we        = we;
    rf_waddr     = wa;
    rf_wdata     = wd;
    out_ready    = rdy;
    #1;
    if (out_valid && out_ready) begin
      n_pops++;
      drop_sum += int'(out_drop_count);
    end
    model_step(rv, pc, insn, we, wa, wd, rdy);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, rdy);
  endtask

  task automatic ev(input logic [31:0] pc, input logic [15:0] k, input logic rdy);
    cycle(1'b1, pc, {16'h1500, k}, 1'b0, 5'd0, 32'h0, rdy);
  endtask

  initial begin
    logic [31:0] insn;
    logic [15:0] k;
    rst_n = 1'b0;
    retire_valid = 1'b0;
    retire_pc = '0;
    retire_insn = '0;
    rf_we = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    out_ready = 1'b0;
    model_reset();
    #3;
    compare_all();
    check("reset_out_pc", 64'(out_pc), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // r3 written in the same cycle as an event nop retires.
    cycle(1'b1, 32'h1000, 32'h15000004, 1'b1, 5'd3, 32'h41, 1'b0);
    check("t1_mon_enable", 64'(mon_enable), 64'h1);
    check("t1_mon_insn", 64'(mon_insn), 64'h15000004);
    check("t1_mon_r3", 64'(mon_r3), 64'h41);
    check("t1_out_valid", 64'(out_valid), 64'h1);
    check("t1_out_r3", 64'(out_r3), 64'h41);
    check("t1_out_overflow", 64'(out_overflow), 64'h0);
    idle(1'b1);

    // Filter: only the non-zero event nop is captured.
    cycle(1'b1, 32'h2000, 32'h15000000, 1'b0, 5'd0, 32'h0, 1'b0);
    check("t2_mon_en0", 64'(mon_enable), 64'h1);
    cycle(1'b1, 32'h2004, 32'h9C600001, 1'b0, 5'd0, 32'h0, 1'b0);
    check("t2_mon_en1", 64'(mon_enable), 64'h1);
    cycle(1'b1, 32'h2008, 32'h15000001, 1'b0, 5'd0, 32'h0, 1'b0);
    check("t2_mon_en2", 64'(mon_enable), 64'h1);
    check("t2_head_insn", 64'(out_insn), 64'h15000001);
    idle(1'b1);
    check("t2_one_entry", 64'(out_valid), 64'h0);

    // Fill, drop three, then push with a simultaneous pop.
    for (int i = 0; i < 8; i++) ev(32'h3000 + 32'(i * 4), 16'(i + 1), 1'b0);
    for (int i = 0; i < 3; i++) ev(32'h3100 + 32'(i * 4), 16'(i + 20), 1'b0);
    ev(32'h3200, 16'h0077, 1'b1);
    for (int i = 0; i < 7; i++) idle(1'b1);
    check("t3_head_pc", 64'(out_pc), 64'h3200);
    check("t3_overflow", 64'(out_overflow), 64'h1);
    check("t3_drop_count", 64'(out_drop_count), 64'h3);
    ev(32'h3204, 16'h0078, 1'b1);
    check("t3_next_overflow", 64'(out_overflow), 64'h0);
    check("t3_next_drop_count", 64'(out_drop_count), 64'h0);
    idle(1'b1);

    // Full FIFO, pop and capture together: accepted, nothing dropped.
    for (int i = 0; i < 8; i++) ev(32'h4000 + 32'(i * 4), 16'(i + 1), 1'b0);
    ev(32'h4100, 16'h0055, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("t4_valid", 64'(out_valid), 64'h1);
      check("t4_no_drop", 64'(out_drop_count), 64'h0);
      idle(1'b1);
    end
    check("t4_drained", 64'(out_valid), 64'h0);

    // Asynchronous reset with five entries and a pending drop count.
    for (int i = 0; i < 8; i++) ev(32'h5000 + 32'(i * 4), 16'(i + 1), 1'b0);
    ev(32'h5100, 16'h0009, 1'b0);
    ev(32'h5104, 16'h000A, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_out_valid", 64'(out_valid), 64'h0);
    check("t5_mon_enable", 64'(mon_enable), 64'h0);
    check("t5_mon_pc", 64'(mon_pc), 64'h0);
    check("t5_mon_insn", 64'(mon_insn), 64'h0);
    check("t5_mon_r3", 64'(mon_r3), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ev(32'h5200, 16'h0033, 1'b0);
    check("t5_after_valid", 64'(out_valid), 64'h1);
    check("t5_after_drop", 64'(out_drop_count), 64'h0);
    check("t5_after_ovf", 64'(out_overflow), 64'h0);
    idle(1'b1);

    // Randomized traffic; the FIFO starts empty with no pending drops.
    n_attempts = 0;
    n_pops = 0;
    drop_sum = 0;
    for (int i = 0; i < 400; i++) begin
      k = 16'($urandom_range(1, 65535));
      case ($urandom % 4)
        0, 1:    insn = {16'h1500, k};
        2:       insn = 32'h15000000;
        default: insn = $urandom;
      endcase
      cycle(($urandom % 8) != 0, $urandom, insn, $urandom % 2,
            ($urandom % 2) ? 5'd3 : 5'($urandom), $urandom, $urandom % 2);
    end
    for (int i = 0; i < 12; i++) idle(1'b1);
    // One more event flushes any residual drop count into an entry.
    ev(32'h6000, 16'h0001, 1'b0);
    idle(1'b1);
    check("rand_drained", 64'(out_valid), 64'h0);
    check("rand_accounting", 64'(n_pops + drop_sum), 64'(n_attempts));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trace_collector.md
Name: trace_collector

Overview:
- Sits directly upstream of the per-core trace monitor, between the mor1kx writeback/retire signals and the monitor inputs.
- Keeps a shadow copy of GPR r3 from the register-file write port.
- Drives the monitor's enable/pc/insn/r3 inputs with one registered stage.
- Captures selected retired instructions into a FIFO with a valid/ready output, so a debug/host consumer can drain trace events without stalling the core.
- Overflow is counted, never back-pressured.

Parameters:
FIFO_DEPTH, 8, FIFO entries; power of two, >=2
FILTER_NOP, 1, 1: capture only event nops (insn[31:16]==16'h1500 and insn[15:0]!=0); 0: capture every retired instruction
DROP_W, 16, width of the saturating drop counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
retire_valid  in  1  an instruction retires this cycle
retire_pc  in  32  PC of retiring instruction
retire_insn  in  32  opcode of retiring instruction
rf_we  in  1  register-file write enable
rf_waddr  in  5  register-file write address
rf_wdata  in  32  register-file write data
mon_enable  out  1  to monitor enable
mon_pc  out  32  to monitor wb_pc
mon_insn  out  32  to monitor wb_insn
mon_r3  out  32  to monitor r3
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_pc  out  32  head PC
out_insn  out  32  head opcode
out_r3  out  32  head r3 snapshot
out_overflow  out  1  events were dropped immediately before this entry
out_drop_count  out  DROP_W  number dropped before this entry (0 if out_overflow=0)

Behaviour:
- Reset is asynchronous on rst_n low. All outputs are 0, the shadow r3 is 0, the FIFO is empty, and the drop counter is 0. Deassertion is used synchronously; no capture happens in the cycle rst_n rises.
- Shadow r3:
  - Updates when rf_we && rf_waddr==5'd3.
  - snap_r3 = (rf_we && rf_waddr==3) ? rf_wdata : shadow. This bypasses a same-cycle write, so the snapshot is the architectural value after the retiring instruction.
- Monitor path, latency 1 cycle: mon_enable<=retire_valid; mon_pc<=retire_pc; mon_insn<=retire_insn; mon_r3<=snap_r3.
  - mon_pc/insn/r3 are updated only when retire_valid=1; otherwise they hold.
  - mon_enable is updated every cycle.
- Capture condition:
  - cap = retire_valid && (FILTER_NOP==0 || (retire_insn[31:16]==16'h1500 && retire_insn[15:0]!=16'h0000)).
  - A plain l.nop 0 is never captured when FILTER_NOP=1.
- FIFO push, entry = {retire_pc, retire_insn, snap_r3, ovf, dcnt}:
  - Push happens when cap && (!full || pop), where pop = out_valid && out_ready. A push into a full FIFO is therefore accepted when a pop occurs in the same cycle.
  - On push: ovf = (drop_cnt!=0), dcnt = drop_cnt, and drop_cnt<=0 in the same cycle.
  - On cap && full && !pop: no push; drop_cnt<=drop_cnt+1, saturating at all-ones.
- FIFO output, first-word-fall-through:
  - out_valid = !empty.
  - out_* present the head entry combinationally from storage.
  - A push at cycle N into an empty FIFO gives out_valid=1 at N+1.
  - While out_valid && !out_ready, all out_* stay stable.
- Pointers: log2(FIFO_DEPTH)+1 bits each, wrapping naturally. full = MSBs differ and lower bits equal; empty = pointers equal.
- Pop on an empty FIFO is impossible because out_valid=0. Simultaneous push and pop on a non-empty, non-full FIFO keeps the level unchanged.
- Reset mid-operation discards all FIFO contents and the drop count immediately (asynchronously).

Test Plan:
- Reset, then rf_we=1, rf_waddr=3, rf_wdata=0x41, with retire_insn=0x15000004 in the same cycle -> next cycle mon_enable=1, mon_insn=0x15000004, mon_r3=0x41; out_valid=1 with out_r3=0x41, out_overflow=0.
- FILTER_NOP=1; retire 0x15000000, 0x9C600001, 0x15000001 on consecutive cycles -> exactly one FIFO entry (insn 0x15000001). mon_enable is high for all three cycles.
- out_ready=0; 8 event nops fill the FIFO, then 3 more -> those 3 are dropped. Raise out_ready, then push one more -> that entry has out_overflow=1, out_drop_count=3, and the next entry has overflow=0.
- Full FIFO with out_ready=1 and cap in the same cycle -> push accepted, level stays 8, no drop counted.
- out_ready toggled 0/1 pseudo-randomly with a push every cycle (FILTER_NOP=0) -> output order matches retire order, out_* stable while stalled, and total pops plus drop_count equals total pushes.
- Assert rst_n low while the FIFO holds 5 entries -> out_valid=0 and mon_* are 0 immediately. After release, a single event nop appears with out_drop_count=0.
